// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin two-requester write arbiter in front of a shared FIFO
// Optional transfer/cap statistics outputs are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arb #(
   parameter int W    = 8,
   parameter int LOGB = 4
) (
   input  logic         clk,
   input  logic         i_reset,
   input  logic         i_a_valid,
   input  logic [W-1:0] i_a_data,
   input  logic         i_a_last,
   output logic         o_a_ready,
   input  logic         i_b_valid,
   input  logic [W-1:0] i_b_data,
   input  logic         i_b_last,
   output logic         o_b_ready,
   output logic         o_fifo_wr,
   output logic [W-1:0] o_fifo_data,
   input  logic         i_fifo_full,
   output logic         o_owner,
   output logic         o_busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [15:0]  o_a_count,
   output logic [15:0]  o_b_count,
   output logic [7:0]   o_cap_count
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_A = 2'd1;
   localparam logic [1:0] GNT_B = 2'd2;
   localparam logic [LOGB:0] CAP = {1'b1, {LOGB{1'b0}}};

   logic [1:0]    state_q, state_d;
   logic          prio_q, prio_d;
   logic [LOGB:0] cnt_q, cnt_d;
   logic          owner_q, owner_d;

   logic          xfer_a, xfer_b, xfer, cur_last, cap_hit, rel_x;
   logic [LOGB:0] cnt_inc;

   // Readies are also gated by reset so a mid-packet reset cannot sneak out a write.
   assign o_a_ready   = (state_q == GNT_A) && !i_fifo_full && !i_reset;
   assign o_b_ready   = (state_q == GNT_B) && !i_fifo_full && !i_reset;
   assign xfer_a      = o_a_ready && i_a_valid;
   assign xfer_b      = o_b_ready && i_b_valid;
   assign xfer        = xfer_a || xfer_b;
   assign o_fifo_wr   = xfer;
   assign o_fifo_data = owner_q ? i_b_data : i_a_data;
   assign cur_last    = owner_q ? i_b_last : i_a_last;
   assign cnt_inc     = cnt_q + 1'b1;
   assign cap_hit     = (cnt_inc == CAP);
   assign rel_x       = xfer && (cur_last || cap_hit);
   assign o_owner     = owner_q;
   assign o_busy      = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if (i_a_valid && (!i_b_valid || !prio_q)) begin
               state_d = GNT_A;
               owner_d = 1'b0;
            end else if (i_b_valid) begin
               state_d = GNT_B;
               owner_d = 1'b1;
            end
         end
         GNT_A, GNT_B: begin
            if (rel_x) begin
               state_d = IDLE;
               cnt_d   = '0;
               prio_d  = !owner_q;
            end else if (xfer) begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] a_cnt_q, b_cnt_q;
   logic [7:0]  cap_cnt_q;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         a_cnt_q   <= '0;
         b_cnt_q   <= '0;
         cap_cnt_q <= '0;
      end else begin
         if (xfer_a) a_cnt_q <= a_cnt_q + 16'd1;
         if (xfer_b) b_cnt_q <= b_cnt_q + 16'd1;
         if (rel_x && !cur_last && cap_cnt_q != 8'hFF) cap_cnt_q <= cap_cnt_q + 8'd1;
      end
   end

   assign o_a_count   = a_cnt_q;
   assign o_b_count   = b_cnt_q;
   assign o_cap_count = cap_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - self-checking bench for fifo_wr_arb
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_fifo_wr_arb;
   localparam int W   = 8;
   localparam int CAP = 16;

   logic clk = 1'b0;
   logic reset, a_valid, a_last, b_valid, b_last, fifo_full;
   logic [W-1:0] a_data, b_data, fifo_data;
   logic a_ready, b_ready, fifo_wr, owner, busy;
`ifdef FIFO_ARB_STATS_EN
   logic [15:0] a_count, b_count;
   logic [7:0]  cap_count;
`endif

   int vec = 0;
   int bad = 0;

   always #5 clk = ~clk;

   fifo_wr_arb #(.W(W), .LOGB(4)) dut (
      .clk(clk), .i_reset(reset),
      .i_a_valid(a_valid), .i_a_data(a_data), .i_a_last(a_last), .o_a_ready(a_ready),
      .i_b_valid(b_valid), .i_b_data(b_data), .i_b_last(b_last), .o_b_ready(b_ready),
      .o_fifo_wr(fifo_wr), .o_fifo_data(fifo_data), .i_fifo_full(fifo_full),
      .o_owner(owner), .o_busy(busy)
`ifdef FIFO_ARB_STATS_EN
      , .o_a_count(a_count), .o_b_count(b_count), .o_cap_count(cap_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      a_valid = 0; a_last = 0; a_data = '0;
      b_valid = 0; b_last = 0; b_data = '0;
      fifo_full = 0;
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      a_valid = 1; b_valid = 1;
      reset = 1;
      tick();
      reset = 0;
      @(negedge clk);
      vec++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || fifo_wr !== 1'b0 || busy !== 1'b0 || owner !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: ra=%b rb=%b wr=%b busy=%b owner=%b want all 0", a_ready, b_ready, fifo_wr, busy, owner);
      end
      tick();
      a_valid = 0; b_valid = 0;
      tick();
   endtask

   task automatic test_single_a();
      logic [7:0] d [3];
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      do_reset();
      a_valid = 1; a_data = d[0]; a_last = 0;
      @(negedge clk);
      vec++;
      if (fifo_wr !== 1'b0 || a_ready !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_a_latency: wr=%b ready=%b busy=%b want 0 0 0", fifo_wr, a_ready, busy);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         a_data = d[k]; a_last = (k == 2);
         @(negedge clk);
         vec++;
         if (fifo_wr !== 1'b1 || fifo_data !== d[k]) begin
            bad++;
            $display("FAIL single_a_word%0d: wr=%b data=%h want 1 %h", k, fifo_wr, fifo_data, d[k]);
         end
         tick();
      end
      a_valid = 0; a_last = 0;
      @(negedge clk);
      vec++;
      if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
         bad++;
         $display("FAIL single_a_bubble: busy=%b wr=%b want 0 0", busy, fifo_wr);
      end
      tick();
      a_valid = 1; a_data = 8'h5A; a_last = 1;
      b_valid = 1; b_data = 8'h5B; b_last = 1;
      tick();
      @(negedge clk);
      vec++;
      if (owner !== 1'b1 || fifo_wr !== 1'b1 || fifo_data !== 8'h5B || a_ready !== 1'b0) begin
         bad++;
         $display("FAIL single_a_prio_b: owner=%b wr=%b data=%h ra=%b want 1 1 5b 0", owner, fifo_wr, fifo_data, a_ready);
      end
      tick();
      a_valid = 0; b_valid = 0; a_last = 0; b_last = 0;
      tick();
   endtask

   task automatic test_both_first();
      logic [5:0] exp_wr, exp_own;
      logic [7:0] q [$];
      int ia = 0, ib = 0;
      exp_wr  = 6'b110110;
      exp_own = 6'b110000;
      q = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         a_valid = (ia < 2); a_data = 8'(8'hA0 + ia); a_last = (ia == 1);
         b_valid = (ib < 2); b_data = 8'(8'hB0 + ib); b_last = (ib == 1);
         @(negedge clk);
         vec++;
         if (fifo_wr !== exp_wr[c] || owner !== exp_own[c]) begin
            bad++;
            $display("FAIL both_cycle%0d: wr=%b owner=%b want %b %b", c, fifo_wr, owner, exp_wr[c], exp_own[c]);
         end
         if (fifo_wr === 1'b1 && q.size() > 0) begin
            vec++;
            if (fifo_data !== q[0]) begin
               bad++;
               $display("FAIL both_data%0d: data=%h want %h", c, fifo_data, q[0]);
            end
            void'(q.pop_front());
         end
         if (a_valid && a_ready) ia++;
         if (b_valid && b_ready) ib++;
         tick();
      end
      do_reset();
   endtask

   task automatic test_burst_cap();
      logic [7:0] q [$];
      logic ew;
      int ia = 0, ib = 0;
      for (int k = 0; k < 16; k++) q.push_back(8'(8'h40 + k));
      q.push_back(8'hA0); q.push_back(8'hA1);
      for (int k = 16; k < 20; k++) q.push_back(8'(8'h40 + k));
      do_reset();
      for (int c = 0; c < 26; c++) begin
         b_valid = (ib < 20); b_data = 8'(8'h40 + ib); b_last = 0;
         a_valid = (c >= 2 && ia < 2); a_data = 8'(8'hA0 + ia); a_last = (ia == 1);
         ew = (c >= 1 && c <= 16) || c == 18 || c == 19 || (c >= 21 && c <= 24);
         @(negedge clk);
         vec++;
         if (fifo_wr !== ew) begin
            bad++;
            $display("FAIL cap_wr_cycle%0d: wr=%b want %b", c, fifo_wr, ew);
         end
         if (fifo_wr === 1'b1 && q.size() > 0) begin
            vec++;
            if (fifo_data !== q[0]) begin
               bad++;
               $display("FAIL cap_data_cycle%0d: data=%h want %h", c, fifo_data, q[0]);
            end
            void'(q.pop_front());
         end
         if (c == 17) begin
            vec++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL cap_release: busy=%b want 0", busy);
            end
`ifdef FIFO_ARB_STATS_EN
            vec++;
            if (cap_count !== 8'd1) begin
               bad++;
               $display("FAIL cap_count: got %0d want 1", cap_count);
            end
`endif
         end
         if (c == 18) begin
            vec++;
            if (owner !== 1'b0) begin
               bad++;
               $display("FAIL cap_next_owner: owner=%b want 0", owner);
            end
         end
         if (a_valid && a_ready) ia++;
         if (b_valid && b_ready) ib++;
         tick();
      end
      do_reset();
   endtask

   task automatic test_full_stall();
      logic [7:0] q [$];
      logic ew, er;
      int ia = 0;
      for (int k = 0; k < 8; k++) q.push_back(8'(8'hC0 + k));
      do_reset();
      for (int c = 0; c < 15; c++) begin
         a_valid = (ia < 8); a_data = 8'(8'hC0 + ia); a_last = (ia == 7);
         fifo_full = (c >= 3 && c <= 7);
         ew = (c == 1 || c == 2 || (c >= 8 && c <= 13));
         er = (c >= 1 && c <= 13 && !fifo_full);
         @(negedge clk);
         vec++;
         if (fifo_wr !== ew || a_ready !== er) begin
            bad++;
            $display("FAIL full_cycle%0d: wr=%b ready=%b want %b %b", c, fifo_wr, a_ready, ew, er);
         end
         if (fifo_wr === 1'b1 && q.size() > 0) begin
            vec++;
            if (fifo_data !== q[0]) begin
               bad++;
               $display("FAIL full_data_cycle%0d: data=%h want %h", c, fifo_data, q[0]);
            end
            void'(q.pop_front());
         end
`ifdef FIFO_ARB_STATS_EN
         if (c == 7) begin
            vec++;
            if (a_count !== 16'd2) begin
               bad++;
               $display("FAIL full_count_frozen: got %0d want 2", a_count);
            end
         end
`endif
         if (a_valid && a_ready) ia++;
         tick();
      end
      do_reset();
   endtask

   task automatic test_reset_mid_b();
      int ib = 0;
      do_reset();
      b_valid = 1; b_last = 0;
      for (int c = 0; c < 3; c++) begin
         b_data = 8'(8'hD0 + ib);
         @(negedge clk);
         vec++;
         if (fifo_wr !== (c > 0) || (c > 0 && fifo_data !== 8'(8'hD0 + c - 1))) begin
            bad++;
            $display("FAIL rstb_cycle%0d: wr=%b data=%h want %b %h", c, fifo_wr, fifo_data, c > 0, 8'(8'hD0 + c - 1));
         end
         if (b_ready) ib++;
         tick();
      end
      reset = 1; b_data = 8'(8'hD0 + ib);
      @(negedge clk);
      vec++;
      if (fifo_wr !== 1'b0) begin
         bad++;
         $display("FAIL rstb_reset_cycle: wr=%b want 0", fifo_wr);
      end
      tick();
      reset = 0;
      b_valid = 0; a_valid = 1; a_data = 8'hE1; a_last = 1;
      @(negedge clk);
      vec++;
      if (busy !== 1'b0 || b_ready !== 1'b0 || a_ready !== 1'b0 || fifo_wr !== 1'b0) begin
         bad++;
         $display("FAIL rstb_after: busy=%b rb=%b ra=%b wr=%b want 0 0 0 0", busy, b_ready, a_ready, fifo_wr);
      end
      tick();
      @(negedge clk);
      vec++;
      if (owner !== 1'b0 || fifo_wr !== 1'b1 || fifo_data !== 8'hE1) begin
         bad++;
         $display("FAIL rstb_a_grant: owner=%b wr=%b data=%h want 0 1 e1", owner, fifo_wr, fifo_data);
      end
      tick();
      do_reset();
   endtask

   task automatic test_fifo_capacity();
      int occ = 0, ia = 0;
      do_reset();
      for (int c = 0; c < 25; c++) begin
         fifo_full = (occ >= 7);
         a_valid = (ia < 10); a_data = 8'(8'h60 + ia); a_last = (ia == 9);
         @(negedge clk);
         vec++;
         if (fifo_wr === 1'b1 && fifo_full === 1'b1) begin
            bad++;
            $display("FAIL cap7_write_when_full: cycle %0d wr=1 full=1 want wr 0", c);
         end
         if (fifo_wr === 1'b1) occ++;
         if (a_valid && a_ready) ia++;
         tick();
      end
      fifo_full = (occ >= 7);
      @(negedge clk);
      vec++;
      if (occ != 7 || a_ready !== 1'b0) begin
         bad++;
         $display("FAIL cap7_total: writes=%0d ready=%b want 7 0", occ, a_ready);
      end
      tick();
      do_reset();
   endtask

   task automatic test_random();
      int holder = -1, sent = 0, turn = 0, last_owner = 0;
      int na = 0, nb = 0, ncap = 0;
      logic era, erb, ewr, lst;
      logic [7:0] ed;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         a_valid = ($urandom % 4) != 0; a_data = 8'($urandom); a_last = ($urandom % 5) == 0;
         b_valid = ($urandom % 4) != 0; b_data = 8'($urandom); b_last = ($urandom % 5) == 0;
         fifo_full = ($urandom % 4) == 0;
         era = (holder == 0) && !fifo_full;
         erb = (holder == 1) && !fifo_full;
         ewr = (era && a_valid) || (erb && b_valid);
         ed  = (holder == 1) ? b_data : a_data;
         @(negedge clk);
         vec++;
         if (a_ready !== era || b_ready !== erb || fifo_wr !== ewr || busy !== (holder != -1) ||
             owner !== last_owner[0] || (ewr && fifo_data !== ed)) begin
            bad++;
            $display("FAIL random_cycle%0d: ra=%b rb=%b wr=%b busy=%b own=%b data=%h want %b %b %b %b %b %h",
                     c, a_ready, b_ready, fifo_wr, busy, owner, fifo_data, era, erb, ewr, holder != -1, last_owner[0], ed);
         end
         if (holder == -1) begin
            if (a_valid && (!b_valid || turn == 0)) holder = 0;
            else if (b_valid) holder = 1;
            if (holder != -1) last_owner = holder;
         end else if (ewr) begin
            if (holder == 0) na++; else nb++;
            sent++;
            lst = (holder == 1) ? b_last : a_last;
            if (lst || sent == CAP) begin
               if (!lst) ncap++;
               turn = 1 - holder;
               holder = -1;
               sent = 0;
            end
         end
         tick();
      end
`ifdef FIFO_ARB_STATS_EN
      vec++;
      if (a_count !== 16'(na) || b_count !== 16'(nb) || cap_count !== 8'(ncap)) begin
         bad++;
         $display("FAIL random_stats: a=%0d b=%0d cap=%0d want %0d %0d %0d", a_count, b_count, cap_count, na, nb, ncap);
      end
`else
      if (na + nb + ncap < 0) $display("unreachable");
`endif
      do_reset();
   endtask

   initial begin
      reset = 1;
      a_valid = 0; a_last = 0; a_data = '0;
      b_valid = 0; b_last = 0; b_data = '0;
      fifo_full = 0;
      tick();
      test_reset();
      test_single_a();
      test_both_first();
      test_burst_cap();
      test_full_stall();
      test_reset_mid_b();
      test_fifo_capacity();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
